// File: rtl/pkt_parse_pkg.sv
// pkt_parse_pkg: shared demo packet types and the channel-index width helper.
//   pkt_ctl_s  - control sideband (eop)
//   pkt_data_s - data beat (flags, payload)
//   ch_w()     - width of a channel index, at least 1 bit
package pkt_parse_pkg;
    typedef logic [7:0] payload_t;
    typedef struct packed {
        logic eop;
    } pkt_ctl_s;
    typedef struct packed {
        logic [3:0] flags;
        payload_t   payload;
    } pkt_data_s;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pkt_payload_fifo.sv
// pkt_payload_fifo: single-clock payload FIFO with extra-MSB wrap pointers.
//   clk, rst_n      - clock, synchronous active-low reset
//   push_i, din_i   - write request and data (ignored when full)
//   pop_i           - read request (ignored when empty)
//   head_o          - oldest entry, valid while !empty_o
//   full_o, empty_o - occupancy flags from the registered pointers
module pkt_payload_fifo import pkt_parse_pkg::*; #(
    parameter type data_t = payload_t,
    parameter int  DEPTH  = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  logic  pop_i,
    input  data_t din_i,
    output data_t head_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int AW = $clog2(DEPTH);
    data_t         mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign wr_d    = (push_i && !full_o) ? wr_q + 1'b1 : wr_q;
    assign rd_d    = (pop_i && !empty_o) ? rd_q + 1'b1 : rd_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk)
        if (rst_n && push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/pkt_payload_parse_mc.sv
// pkt_payload_parse_mc: queues flagged end-of-packet payloads from NUM_CH streams
// into per-channel FIFOs and merges them round-robin onto one valid/ready output.
//   clk, rst_n                        - clock, synchronous active-low reset
//   pkt_valid/pkt_ready               - per-channel beat handshake
//   pkt_ctl_data, pkt_data            - per-channel control (eop) and data (flags, payload)
//   out_valid/out_ready               - merged output handshake
//   out_payload, out_ch               - head payload of the granted FIFO and its channel
//   drop_cnt                          - per-channel saturating drop counters, present
//                                       only when PKT_PARSE_DROP_CNT_EN is defined
module pkt_payload_parse_mc import pkt_parse_pkg::*; #(
    parameter type     pkt_ctl_t          = pkt_ctl_s,
    parameter type     pkt_data_t         = pkt_data_s,
    parameter type     pkt_data_payload_t = payload_t,
    parameter int      NUM_CH             = 4,
    parameter int      FIFO_DEPTH         = 4,
    parameter int      DROP_ON_FULL       = 0,
    parameter int      CNT_W              = 16,
    localparam int     CH_W               = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pkt_valid,
    output logic [NUM_CH-1:0] pkt_ready,
    input  pkt_ctl_t          pkt_ctl_data [NUM_CH],
    input  pkt_data_t         pkt_data [NUM_CH],
    output logic              out_valid,
    input  logic              out_ready,
    output pkt_data_payload_t out_payload,
`ifdef PKT_PARSE_DROP_CNT_EN
    output logic [CH_W-1:0]   out_ch,
    output logic [CNT_W-1:0]  drop_cnt [NUM_CH]
`else
    output logic [CH_W-1:0]   out_ch
`endif
);
    logic [NUM_CH-1:0] full, empty, qual, push, pop;
    pkt_data_payload_t head [NUM_CH];
    logic [CH_W-1:0]   rr_q, rr_d, rr_gnt, gnt_q, gnt, idx;
    logic              lock_q, lock_d, hs;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Readiness depends only on registered fullness, never on out_ready.
        assign pkt_ready[i] = rst_n && (DROP_ON_FULL != 0 || !full[i]);
        assign qual[i]      = pkt_valid[i] && pkt_ready[i] && pkt_ctl_data[i].eop && |pkt_data[i].flags;
        assign push[i]      = qual[i] && !full[i];
        assign pop[i]       = hs && gnt == CH_W'(i);
        pkt_payload_fifo #(.data_t(pkt_data_payload_t), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push_i (push[i]),
            .pop_i  (pop[i]),
            .din_i  (pkt_data[i].payload),
            .head_o (head[i]),
            .full_o (full[i]),
            .empty_o(empty[i])
        );
`ifdef PKT_PARSE_DROP_CNT_EN
        logic [CNT_W-1:0] cnt_q;
        // A qualifying beat seen against a full FIFO is lost even if that FIFO pops this cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) cnt_q <= '0;
            else if (qual[i] && full[i] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        assign drop_cnt[i] = cnt_q;
`endif
    end
    // Scan downward so the nonempty channel nearest to rr_q is the last one assigned.
    always_comb begin
        rr_gnt = rr_q;
        idx    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(rr_q) + k) % NUM_CH);
            if (!empty[idx]) rr_gnt = idx;
        end
    end
    // A stalled grant stays locked so the offered payload cannot change under the consumer.
    assign gnt         = lock_q ? gnt_q : rr_gnt;
    assign out_valid   = rst_n && !(&empty);
    assign hs          = out_valid && out_ready;
    assign out_payload = out_valid ? head[gnt] : '0;
    assign out_ch      = out_valid ? gnt : '0;
    assign lock_d      = out_valid && !out_ready;
    assign rr_d        = !hs ? rr_q : (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q   <= '0;
            gnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            gnt_q  <= gnt;
            lock_q <= lock_d;
        end
    end
endmodule
